// File: rtl/multi_channel_data_sink.sv
// N-channel valid/ready data sink with programmable backpressure and per-channel
// transfer count, last value and inter-arrival interval statistics.
module multi_channel_data_sink #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned BL    = 0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NCH-1:0]                         in_valid,
  input  logic [NCH*WIDTH-1:0]                   in_data,
  output logic [NCH-1:0]                         in_ready,
  input  logic                                   clear,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] rd_ch,
  input  logic [2:0]                             rd_sel,
  output logic [CNT_W-1:0]                       rd_data
);

  localparam int unsigned CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned SW     = (BL > 1) ? $clog2(BL) : 1;
  localparam logic        HAS_BP = (BL > 0);

  localparam logic [0:0] READY = 1'b0;
  localparam logic [0:0] STALL = 1'b1;

  logic [0:0]       state     [NCH];
  logic [0:0]       stateNext [NCH];
  logic [SW-1:0]    stallCnt  [NCH];
  logic [SW-1:0]    stallNext [NCH];
  logic [NCH-1:0]   xfer;

  logic [CNT_W-1:0] count   [NCH];
  logic [CNT_W-1:0] sum     [NCH];
  logic [CNT_W-1:0] minV    [NCH];
  logic [CNT_W-1:0] maxV    [NCH];
  logic [CNT_W-1:0] last    [NCH];
  logic [CNT_W-1:0] ts      [NCH];
  logic [NCH-1:0]   hasPrev;
  logic [CNT_W-1:0] gcyc;

  logic [CNT_W-1:0] countN   [NCH];
  logic [CNT_W-1:0] sumN     [NCH];
  logic [CNT_W-1:0] minN     [NCH];
  logic [CNT_W-1:0] maxN     [NCH];
  logic [CNT_W-1:0] lastN    [NCH];
  logic [CNT_W-1:0] tsN      [NCH];
  logic [NCH-1:0]   hasPrevN;
  logic [CNT_W-1:0] gcycN;
  logic [CNT_W-1:0] interval [NCH];
  logic [CNT_W:0]   sumExt   [NCH];
  logic [CNT_W-1:0] rdNext;

  assign xfer = in_valid & in_ready;

  // Per-channel backpressure FSM: BL ready-low cycles after each accepted transfer
  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      stateNext[c] = state[c];
      stallNext[c] = stallCnt[c];
      case (state[c])
        READY: begin
          if (xfer[c] && HAS_BP) begin
            stateNext[c] = STALL;
            stallNext[c] = SW'(BL - 1);
          end
        end
        STALL: begin
          if (stallCnt[c] == '0) stateNext[c] = READY;
          else                   stallNext[c] = stallCnt[c] - SW'(1);
        end
        default: stateNext[c] = READY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready <= '1;
      for (int unsigned c = 0; c < NCH; c++) begin
        state[c]    <= READY;
        stallCnt[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        state[c]    <= stateNext[c];
        stallCnt[c] <= stallNext[c];
        in_ready[c] <= (stateNext[c] == READY);
      end
    end
  end

  // Statistics next-state; clear overrides any same-cycle transfer
  always_comb begin
    gcycN    = (gcyc == '1) ? gcyc : gcyc + CNT_W'(1);
    hasPrevN = hasPrev;
    for (int unsigned c = 0; c < NCH; c++) begin
      countN[c]   = count[c];
      sumN[c]     = sum[c];
      minN[c]     = minV[c];
      maxN[c]     = maxV[c];
      lastN[c]    = last[c];
      tsN[c]      = ts[c];
      interval[c] = gcyc - ts[c];
      sumExt[c]   = {1'b0, sum[c]} + {1'b0, interval[c]};
      if (clear) begin
        countN[c]   = '0;
        sumN[c]     = '0;
        minN[c]     = '1;
        maxN[c]     = '0;
        lastN[c]    = '0;
        tsN[c]      = '0;
        hasPrevN[c] = 1'b0;
      end else if (xfer[c]) begin
        countN[c]   = (count[c] == '1) ? count[c] : count[c] + CNT_W'(1);
        lastN[c]    = CNT_W'(in_data[c*WIDTH +: WIDTH]);
        tsN[c]      = gcyc;
        hasPrevN[c] = 1'b1;
        if (hasPrev[c]) begin
          sumN[c] = sumExt[c][CNT_W] ? '1 : sumExt[c][CNT_W-1:0];
          if (interval[c] < minV[c]) minN[c] = interval[c];
          if (interval[c] > maxV[c]) maxN[c] = interval[c];
        end
      end
    end
    if (clear) gcycN = '0;
  end

  // Readout mux over post-update values; out-of-range channels read zero
  always_comb begin
    rdNext = '0;
    if (rd_sel == 3'd5) begin
      rdNext = gcycN;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (rd_ch == CH_W'(c)) begin
          case (rd_sel)
            3'd0:    rdNext = countN[c];
            3'd1:    rdNext = sumN[c];
            3'd2:    rdNext = minN[c];
            3'd3:    rdNext = maxN[c];
            3'd4:    rdNext = lastN[c];
            3'd6:    rdNext = tsN[c];
            default: rdNext = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gcyc    <= '0;
      hasPrev <= '0;
      rd_data <= '0;
      for (int unsigned c = 0; c < NCH; c++) begin
        count[c] <= '0;
        sum[c]   <= '0;
        minV[c]  <= '1;
        maxV[c]  <= '0;
        last[c]  <= '0;
        ts[c]    <= '0;
      end
    end else begin
      gcyc    <= gcycN;
      hasPrev <= hasPrevN;
      rd_data <= rdNext;
      for (int unsigned c = 0; c < NCH; c++) begin
        count[c] <= countN[c];
        sum[c]   <= sumN[c];
        minV[c]  <= minN[c];
        maxV[c]  <= maxN[c];
        last[c]  <= lastN[c];
        ts[c]    <= tsN[c];
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_data_sink.sv
// Directed bench for multi_channel_data_sink: three instances covering BL=0,
// BL=2 and BL=3 (NCH=3, for out-of-range readout).
module tb_multi_channel_data_sink;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  logic [3:0]  v0, r0;
  logic [31:0] d0, q0;
  logic        clr0;
  logic [1:0]  rc0;
  logic [2:0]  rs0;

  logic [3:0]  v2, r2;
  logic [31:0] d2, q2;
  logic        clr2;
  logic [1:0]  rc2;
  logic [2:0]  rs2;

  logic [2:0]  v3, r3;
  logic [23:0] d3;
  logic [31:0] q3;
  logic        clr3;
  logic [1:0]  rc3;
  logic [2:0]  rs3;

  multi_channel_data_sink #(.WIDTH(8), .NCH(4), .CNT_W(32), .BL(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(v0), .in_data(d0), .in_ready(r0),
    .clear(clr0), .rd_ch(rc0), .rd_sel(rs0), .rd_data(q0));

  multi_channel_data_sink #(.WIDTH(8), .NCH(4), .CNT_W(32), .BL(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(v2), .in_data(d2), .in_ready(r2),
    .clear(clr2), .rd_ch(rc2), .rd_sel(rs2), .rd_data(q2));

  multi_channel_data_sink #(.WIDTH(8), .NCH(3), .CNT_W(32), .BL(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(v3), .in_data(d3), .in_ready(r3),
    .clear(clr3), .rd_ch(rc3), .rd_sel(rs3), .rd_data(q3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd0(input logic [1:0] ch, input logic [2:0] sel, input logic [31:0] exp, input string tag);
    rc0 = ch; rs0 = sel;
    tick();
    chk(tag, q0, exp);
  endtask

  task automatic rd2(input logic [1:0] ch, input logic [2:0] sel, input logic [31:0] exp, input string tag);
    rc2 = ch; rs2 = sel;
    tick();
    chk(tag, q2, exp);
  endtask

  task automatic rd3(input logic [1:0] ch, input logic [2:0] sel, input logic [31:0] exp, input string tag);
    rc3 = ch; rs3 = sel;
    tick();
    chk(tag, q3, exp);
  endtask

  logic [6:0] readyPat;

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1;
    v0 = '0; d0 = '0; clr0 = 1'b0; rc0 = '0; rs0 = '0;
    v2 = '0; d2 = '0; clr2 = 1'b0; rc2 = '0; rs2 = '0;
    v3 = '0; d3 = '0; clr3 = 1'b0; rc3 = '0; rs3 = '0;
    tick(); tick();
    chk("reset_ready0", 32'(r0), 32'hF);
    chk("reset_ready3", 32'(r3), 32'h7);
    chk("reset_rd0", q0, 32'h0);
    reset = 1'b0;

    // BL=0: ch0 streams 1..5 back to back
    for (int i = 1; i <= 5; i++) begin
      v0[0] = 1'b1; d0[7:0] = 8'(i);
      chk("bl0_ready", 32'(r0[0]), 32'h1);
      tick();
    end
    v0 = '0;
    chk("bl0_ready_after", 32'(r0[0]), 32'h1);
    rd0(2'd0, 3'd0, 32'd5, "bl0_count");
    rd0(2'd0, 3'd4, 32'd5, "bl0_last");
    rd0(2'd0, 3'd1, 32'd4, "bl0_sum");
    rd0(2'd0, 3'd2, 32'd1, "bl0_min");
    rd0(2'd0, 3'd3, 32'd1, "bl0_max");

    // all four channels in the same cycle
    clr0 = 1'b1; tick(); clr0 = 1'b0;
    v0 = 4'hF; d0 = 32'h44332211;
    tick();
    v0 = '0;
    rd0(2'd0, 3'd0, 32'd1, "all_count0");
    rd0(2'd0, 3'd4, 32'h11, "all_last0");
    rd0(2'd1, 3'd4, 32'h22, "all_last1");
    rd0(2'd2, 3'd4, 32'h33, "all_last2");
    rd0(2'd3, 3'd4, 32'h44, "all_last3");
    rd0(2'd3, 3'd0, 32'd1, "all_count3");
    rd0(2'd1, 3'd2, 32'hFFFFFFFF, "all_min1");
    rd0(2'd2, 3'd1, 32'd0, "all_sum2");

    // ch2 transfers at gcyc 3, 10, 12 (clear edge leaves gcyc = 0)
    clr0 = 1'b1; tick(); clr0 = 1'b0;
    repeat (3) tick();
    v0[2] = 1'b1; d0[23:16] = 8'h5A; tick(); v0 = '0;
    repeat (6) tick();
    v0[2] = 1'b1; tick(); v0 = '0;
    tick();
    v0[2] = 1'b1; d0[23:16] = 8'hC3; tick(); v0 = '0;
    rd0(2'd2, 3'd1, 32'd9, "iv_sum");
    rd0(2'd2, 3'd2, 32'd2, "iv_min");
    rd0(2'd2, 3'd3, 32'd7, "iv_max");
    rd0(2'd2, 3'd6, 32'd12, "iv_ts");
    rd0(2'd2, 3'd0, 32'd3, "iv_count");
    rd0(2'd2, 3'd5, 32'd19, "iv_gcyc");
    rd0(2'd2, 3'd4, 32'hC3, "iv_last");

    // clear wins over a same-cycle transfer
    v0[0] = 1'b1; d0[7:0] = 8'h99; clr0 = 1'b1; rc0 = 2'd0; rs0 = 3'd5;
    tick();
    v0 = '0; clr0 = 1'b0;
    chk("clr_gcyc", q0, 32'd0);
    chk("clr_ready", 32'(r0), 32'hF);
    rd0(2'd0, 3'd0, 32'd0, "clr_count");
    rd0(2'd0, 3'd2, 32'hFFFFFFFF, "clr_min");
    v0[0] = 1'b1; d0[7:0] = 8'h77; tick(); v0 = '0;
    rd0(2'd0, 3'd0, 32'd1, "clr_next_count");
    rd0(2'd0, 3'd1, 32'd0, "clr_next_sum");
    rd0(2'd0, 3'd2, 32'hFFFFFFFF, "clr_next_min");
    rd0(2'd0, 3'd4, 32'h77, "clr_next_last");

    // BL=2: ch1 valid held high for seven cycles
    v2[1] = 1'b1; d2[15:8] = 8'hA5;
    for (int i = 0; i < 7; i++) begin
      readyPat[i] = r2[1];
      tick();
    end
    v2 = '0;
    chk("bl2_pattern", 32'(readyPat), 32'b1001001);
    rd2(2'd1, 3'd0, 32'd3, "bl2_count");
    rd2(2'd1, 3'd2, 32'd3, "bl2_min");
    rd2(2'd1, 3'd3, 32'd3, "bl2_max");
    rd2(2'd1, 3'd1, 32'd6, "bl2_sum");
    rd2(2'd1, 3'd4, 32'hA5, "bl2_last");
    chk("bl2_other_ready", 32'(r2[0]), 32'h1);

    // BL=3: asynchronous reset in the middle of a stall
    v3[0] = 1'b1; d3[7:0] = 8'h3C; tick(); v3 = '0;
    chk("bl3_stall1", 32'(r3[0]), 32'h0);
    rd3(2'd0, 3'd0, 32'd1, "bl3_count_pre");
    chk("bl3_stall2", 32'(r3[0]), 32'h0);
    #2 reset = 1'b1;
    #1;
    chk("async_ready3", 32'(r3), 32'h7);
    chk("async_rd3", q3, 32'h0);
    chk("async_rd0", q0, 32'h0);
    #2 reset = 1'b0;
    rd3(2'd3, 3'd5, 32'd1, "oor_gcyc");
    rd3(2'd3, 3'd2, 32'd0, "oor_min");
    rd3(2'd3, 3'd0, 32'd0, "oor_count");
    rd3(2'd0, 3'd0, 32'd0, "post_reset_count");
    rd3(2'd0, 3'd4, 32'd0, "post_reset_last");
    rd3(2'd0, 3'd2, 32'hFFFFFFFF, "post_reset_min");
    chk("post_reset_ready", 32'(r3), 32'h7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
